// File: rtl/vram_writer.sv
// vram_writer
//   Turns a valid/ready stream of ASCII bytes into writes on an 80x30
//   character VRAM. It keeps a text cursor and handles CR, LF, BS and FF.
//   LF, or a wrap at column 79, on the last row starts a line clear.
//   FF clears the whole screen one cell per cycle.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          asynchronous, active-high reset
//   i_ch_valid     a byte is offered
//   i_ch_data      ASCII byte, sampled only when the transfer happens
//   o_ch_ready     high only while idle
//   o_vram_we      VRAM write strobe
//   o_vram_addr    physical cell address, 80*physical_row + col
//   o_vram_data    byte written
//   o_cursor_row   logical cursor row, 0..29
//   o_cursor_col   cursor column, 0..79
//   o_scroll_base  physical row shown at the top of the screen
//
// Configuration
//   VRAM_WRITER_SCROLL_EN  defined: a newline on row 29 scrolls by one row.
//                          undefined: scroll_base stays 0, and a newline on
//                          row 29 wraps to row 0 and clears that row.
//
// state        | meaning
// S_IDLE       | ready for a byte
// S_WRITE      | one character or backspace write is on the port
// S_CLR_LINE   | writing 0x20 across the cursor row, col 0..79
// S_CLR_SCREEN | writing 0x20 to addresses 0..2399
module vram_writer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ch_valid,
  input  logic [7:0]  i_ch_data,
  output logic        o_ch_ready,
  output logic        o_vram_we,
  output logic [11:0] o_vram_addr,
  output logic [7:0]  o_vram_data,
  output logic [4:0]  o_cursor_row,
  output logic [6:0]  o_cursor_col,
  output logic [4:0]  o_scroll_base
);

  localparam logic [6:0]  LAST_COL   = 7'd79;
  localparam logic [4:0]  LAST_ROW   = 5'd29;
  localparam logic [11:0] LINE_CELLS = 12'd80;
  localparam logic [11:0] SCR_CELLS  = 12'd2400;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLR_LINE, S_CLR_SCREEN} state_t;

  state_t      r_state, w_state;
  logic [4:0]  r_row, w_row;
  logic [6:0]  r_col, w_col;
  logic [4:0]  r_sb, w_sb;
  logic [11:0] r_cnt, w_cnt;
  logic        r_pend, w_pend;
  logic        r_we, w_we;
  logic [11:0] r_addr, w_addr;
  logic [7:0]  r_data, w_data;

  logic [4:0]  w_nl_row, w_nl_sb;
  logic        w_nl_clr;
  logic        w_xfer, w_printable;

  // Physical address of a logical (row, col). The row sum is at most 58,
  // so a single conditional subtract gives the mod-30 result.
  function automatic logic [11:0] f_addr(input logic [4:0] row,
                                         input logic [4:0] sb,
                                         input logic [6:0] col);
    logic [5:0] sum;
    logic [4:0] prow;
    sum  = {1'b0, row} + {1'b0, sb};
    prow = (sum >= 6'd30) ? 5'(sum - 6'd30) : sum[4:0];
    return {1'b0, prow, 6'b0} + {3'b0, prow, 4'b0} + {5'b0, col};
  endfunction

  assign w_xfer      = i_ch_valid && (r_state == S_IDLE);
  assign w_printable = (i_ch_data >= 8'h20) && (i_ch_data <= 8'h7E);

  // Cursor and scroll position after a newline. w_nl_clr means the row the
  // cursor lands on has to be blanked.
  always_comb begin
    w_nl_row = r_row + 5'd1;
    w_nl_sb  = r_sb;
    w_nl_clr = 1'b0;
    if (r_row == LAST_ROW) begin
      w_nl_clr = 1'b1;
`ifdef VRAM_WRITER_SCROLL_EN
      w_nl_row = LAST_ROW;
      w_nl_sb  = (r_sb == LAST_ROW) ? 5'd0 : r_sb + 5'd1;
`else
      w_nl_row = 5'd0;
      w_nl_sb  = 5'd0;
`endif
    end
  end

  always_comb begin
    w_state = r_state;
    w_row   = r_row;
    w_col   = r_col;
    w_sb    = r_sb;
    w_cnt   = r_cnt;
    w_pend  = r_pend;
    w_we    = 1'b0;
    w_addr  = r_addr;
    w_data  = r_data;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          if (w_printable) begin
            w_we    = 1'b1;
            w_addr  = f_addr(r_row, r_sb, r_col);
            w_data  = i_ch_data;
            w_state = S_WRITE;
            if (r_col != LAST_COL) begin
              w_col = r_col + 7'd1;
            end else begin
              w_col  = 7'd0;
              w_row  = w_nl_row;
              w_sb   = w_nl_sb;
              w_pend = w_nl_clr;
            end
          end else begin
            case (i_ch_data)
              8'h0D: w_col = 7'd0;
              8'h0A: begin
                w_col = 7'd0;
                w_row = w_nl_row;
                w_sb  = w_nl_sb;
                if (w_nl_clr) begin
                  w_state = S_CLR_LINE;
                  w_cnt   = 12'd0;
                end
              end
              8'h08: begin
                if (r_col != 7'd0) begin
                  w_col   = r_col - 7'd1;
                  w_we    = 1'b1;
                  w_addr  = f_addr(r_row, r_sb, r_col - 7'd1);
                  w_data  = 8'h20;
                  w_state = S_WRITE;
                end
              end
              8'h0C: begin
                w_state = S_CLR_SCREEN;
                w_cnt   = 12'd0;
              end
              default: ;
            endcase
          end
        end
      end
      S_WRITE: begin
        // A character written at column 79 of the last row still owes a
        // line clear.
        if (r_pend) begin
          w_pend  = 1'b0;
          w_cnt   = 12'd0;
          w_state = S_CLR_LINE;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_CLR_LINE: begin
        if (r_cnt == LINE_CELLS) begin
          w_state = S_IDLE;
        end else begin
          w_we   = 1'b1;
          w_addr = f_addr(r_row, r_sb, r_cnt[6:0]);
          w_data = 8'h20;
          w_cnt  = r_cnt + 12'd1;
        end
      end
      S_CLR_SCREEN: begin
        if (r_cnt == SCR_CELLS) begin
          w_state = S_IDLE;
          w_row   = 5'd0;
          w_col   = 7'd0;
          w_sb    = 5'd0;
        end else begin
          w_we   = 1'b1;
          w_addr = r_cnt;
          w_data = 8'h20;
          w_cnt  = r_cnt + 12'd1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_row   <= 5'd0;
      r_col   <= 7'd0;
      r_sb    <= 5'd0;
      r_cnt   <= 12'd0;
      r_pend  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 12'd0;
      r_data  <= 8'd0;
    end else begin
      r_state <= w_state;
      r_row   <= w_row;
      r_col   <= w_col;
      r_sb    <= w_sb;
      r_cnt   <= w_cnt;
      r_pend  <= w_pend;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_data  <= w_data;
    end
  end

  assign o_ch_ready   = (r_state == S_IDLE);
  assign o_vram_we    = r_we;
  assign o_vram_addr  = r_addr;
  assign o_vram_data  = r_data;
  assign o_cursor_row = r_row;
  assign o_cursor_col = r_col;
`ifdef VRAM_WRITER_SCROLL_EN
  assign o_scroll_base = r_sb;
`else
  assign o_scroll_base = 5'd0;
`endif

endmodule
